// File: rtl/bist_fail_logger_if.sv
// Compare-stream inputs, log pop port and status for bist_fail_logger.
// BIST_LOG_FIRST_FAIL_EN adds the first-fail address outputs.
interface bist_fail_logger_if #(
  parameter int size   = 6,
  parameter int length = 8
);
  logic              arm;
  logic              test_active;
  logic              rd_cycle;
  logic [2:0]        phase;
  logic [size-1:0]   addr;
  logic [length-1:0] expected;
  logic [length-1:0] actual;
  // Pop handshake: an entry transfers on a rising edge where pop_valid && pop_ready;
  // pop_* hold steady while pop_valid=1 and pop_ready=0.
  logic              pop_valid;
  logic              pop_ready;
  logic [size-1:0]   pop_addr;
  logic [2:0]        pop_phase;
  logic [length-1:0] pop_syndrome;
  logic [15:0]       fail_count;
  logic              overflow;
  logic              done;
  logic [1:0]        state_dbg;
`ifdef BIST_LOG_FIRST_FAIL_EN
  logic              first_fail_valid;
  logic [size-1:0]   first_fail_addr;
`endif

  modport slave (
    input  arm, test_active, rd_cycle, phase, addr, expected, actual, pop_ready,
    output pop_valid, pop_addr, pop_phase, pop_syndrome, fail_count, overflow,
           done, state_dbg
`ifdef BIST_LOG_FIRST_FAIL_EN
    , output first_fail_valid, first_fail_addr
`endif
  );

  modport master (
    output arm, test_active, rd_cycle, phase, addr, expected, actual, pop_ready,
    input  pop_valid, pop_addr, pop_phase, pop_syndrome, fail_count, overflow,
           done, state_dbg
`ifdef BIST_LOG_FIRST_FAIL_EN
    , input first_fail_valid, first_fail_addr
`endif
  );
endinterface

// File: rtl/bist_fail_logger.sv
// Captures BIST compare mismatches into a FWFT FIFO and keeps fail statistics.
// Optional BIST_LOG_FIRST_FAIL_EN latches the address of the session's first mismatch.
module bist_fail_logger #(
  parameter int size   = 6,
  parameter int length = 8,
  parameter int depth  = 8
) (
  input logic clk,
  input logic rst,
  bist_fail_logger_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam int EW = size + 3 + length;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, ARMED, LOGGING, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]     fail_cnt_q, fail_cnt_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   mem_q [depth];
  logic [EW-1:0]   head;
  logic            empty, full, pop, capture, push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // arm flushes the log, so it overrides any pop or capture on the same edge
  assign pop     = !empty && bus.pop_ready && !bus.arm;
  assign capture = (state_q == LOGGING) && bus.test_active && bus.rd_cycle &&
                   (bus.expected != bus.actual) && !bus.arm;
  assign push    = capture && (!full || pop);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fail_cnt_d = fail_cnt_q;
    ovf_d      = ovf_q;
    if (bus.arm) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fail_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      case (state_q)
        ARMED:   if (bus.test_active)  state_d = LOGGING;
        LOGGING: if (!bus.test_active) state_d = DONE;
        default: state_d = state_q;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (capture && fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
      if (capture && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fail_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fail_cnt_q <= fail_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.addr, bus.phase, bus.expected ^ bus.actual};
  end

  // Storage is unreset; gating the head keeps pop_* at zero whenever the log is empty.
  assign head             = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.pop_valid    = !empty;
  assign bus.pop_addr     = head[EW-1 -: size];
  assign bus.pop_phase    = head[length +: 3];
  assign bus.pop_syndrome = head[length-1:0];
  assign bus.fail_count   = fail_cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.done         = (state_q == DONE);
  assign bus.state_dbg    = state_q;

`ifdef BIST_LOG_FIRST_FAIL_EN
  logic            ff_valid_q;
  logic [size-1:0] ff_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_valid_q <= 1'b0;
      ff_addr_q  <= '0;
    end else if (bus.arm) begin
      ff_valid_q <= 1'b0;
      ff_addr_q  <= '0;
    end else if (capture && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_addr_q  <= bus.addr;
    end
  end

  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_addr  = ff_addr_q;
`endif
endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: scoreboard queue checked by a pop-side monitor.
module tb_bist_fail_logger;
  localparam int EW = 6 + 3 + 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [EW-1:0] exp_q[$];

  bist_fail_logger_if #(.size(6), .length(8)) bus ();

  bist_fail_logger #(.size(6), .length(8), .depth(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_session();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.test_active = 1'b1;
    tick();
  endtask

  task automatic cmp_cycle(input logic [5:0] a, input logic [2:0] ph,
                           input logic [7:0] e, input logic [7:0] act);
    bus.rd_cycle = 1'b1;
    bus.addr     = a;
    bus.phase    = ph;
    bus.expected = e;
    bus.actual   = act;
    tick();
    bus.rd_cycle = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.pop_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    bus.pop_ready = 1'b0;
    check({name, "_drain_done"}, exp_q.size(), 0);
  endtask

  // Monitor: every transfer on the pop port must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.pop_valid && bus.pop_ready && !bus.arm) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {bus.pop_addr, bus.pop_phase, bus.pop_syndrome}, 32'hFFFF_FFFF);
      end else begin
        check("pop_entry", {bus.pop_addr, bus.pop_phase, bus.pop_syndrome}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.arm = 1'b0; bus.test_active = 1'b0; bus.rd_cycle = 1'b0; bus.phase = '0;
    bus.addr = '0; bus.expected = '0; bus.actual = '0; bus.pop_ready = 1'b0;
    #12;
    check("rst_pop_valid", bus.pop_valid, 0);
    check("rst_pop_data", {bus.pop_addr, bus.pop_phase, bus.pop_syndrome}, 0);
    check("rst_fail_count", bus.fail_count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.state_dbg, 0);
    #8 rst = 1'b0;
    tick();

    // Clean run
    arm_session();
    check("armed_to_logging", bus.state_dbg, 2);
    for (int i = 0; i < 64; i++) cmp_cycle(i[5:0], 3'd0, 8'h55, 8'h55);
    bus.test_active = 1'b0;
    tick();
    check("clean_fail_count", bus.fail_count, 0);
    check("clean_pop_valid", bus.pop_valid, 0);
    check("clean_overflow", bus.overflow, 0);
    check("clean_done", bus.done, 1);

    // Single fail
    arm_session();
    check("rearm_done_low", bus.done, 0);
    exp_q.push_back({6'h2A, 3'd3, 8'h08});
    cmp_cycle(6'h2A, 3'd3, 8'hFF, 8'hF7);
    check("single_pop_valid", bus.pop_valid, 1);
    check("single_pop_addr", bus.pop_addr, 6'h2A);
    check("single_pop_phase", bus.pop_phase, 3);
    check("single_pop_syndrome", bus.pop_syndrome, 8'h08);
    check("single_fail_count", bus.fail_count, 1);
    tick();
    check("single_hold_stable", {bus.pop_valid, bus.pop_addr, bus.pop_phase, bus.pop_syndrome},
          {1'b1, 6'h2A, 3'd3, 8'h08});
    drain("single");
    check("single_empty", bus.pop_valid, 0);

    // Overflow: ten mismatches into an eight-deep log
    arm_session();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] syn;
      syn = 8'(i + 1);
      if (i < 8) exp_q.push_back({6'(i), 3'd1, syn});
      cmp_cycle(6'(i), 3'd1, 8'h3C, 8'h3C ^ syn);
    end
    check("ovf_fail_count", bus.fail_count, 10);
    check("ovf_overflow", bus.overflow, 1);
`ifdef BIST_LOG_FIRST_FAIL_EN
    check("ovf_first_fail_valid", bus.first_fail_valid, 1);
    check("ovf_first_fail_addr", bus.first_fail_addr, 0);
`endif
    drain("ovf");
    check("ovf_empty", bus.pop_valid, 0);

    // Full log plus simultaneous pop and capture
    arm_session();
    check("full_ovf_cleared", bus.overflow, 0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({6'(16 + i), 3'd5, 8'h80});
      cmp_cycle(6'(16 + i), 3'd5, 8'h80, 8'h00);
    end
    exp_q.push_back({6'h3F, 3'd6, 8'h11});
    bus.pop_ready = 1'b1;
    cmp_cycle(6'h3F, 3'd6, 8'h00, 8'h11);
    check("full_pop_overflow", bus.overflow, 0);
    check("full_pop_fail_count", bus.fail_count, 9);
    drain("full_pop");

    // Re-arm mid-session with pop_ready high
    arm_session();
    for (int i = 0; i < 3; i++) cmp_cycle(6'(40 + i), 3'd2, 8'hAA, 8'hAB);
    check("rearm_fail_count_pre", bus.fail_count, 3);
    bus.arm = 1'b1;
    bus.pop_ready = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.pop_ready = 1'b0;
    check("rearm_pop_valid", bus.pop_valid, 0);
    check("rearm_fail_count", bus.fail_count, 0);
    check("rearm_state", bus.state_dbg, 1);
`ifdef BIST_LOG_FIRST_FAIL_EN
    check("rearm_first_fail_valid", bus.first_fail_valid, 0);
`endif

    // Asynchronous reset while an entry is pending
    tick();
    cmp_cycle(6'h15, 3'd4, 8'hF0, 8'h0F);
    check("async_pre_valid", bus.pop_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("async_pop_valid", bus.pop_valid, 0);
    check("async_pop_data", {bus.pop_addr, bus.pop_phase, bus.pop_syndrome}, 0);
    check("async_fail_count", bus.fail_count, 0);
    check("async_done", bus.done, 0);
    check("async_state", bus.state_dbg, 0);
    #2 rst = 1'b0;
    bus.test_active = 1'b0;
    tick();
    check("post_reset_empty", bus.pop_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bist_fail_logger.md
# bist_fail_logger

Diagnostic capture unit on the readout side of the memory BIST. While the BIST engine writes patterns and compares SRAM read data, this block watches the same compare stream, records every mismatching read (address, pattern phase, XOR syndrome) into a small FIFO, and keeps failure statistics. A host or scan-side reader drains the log through a valid/ready pop port after or during the test, so diagnosis gets per-address detail instead of a single sticky `fail` bit.

## Interface
- `size`, default 6: address width, matches the SRAM address width.
- `length`, default 8: data width, matches the SRAM word width.
- `depth`, default 8: FIFO entries, power of two, minimum 2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `arm` in 1: one-cycle pulse that starts a new logging session.
- `test_active` in 1: high while the BIST engine owns the SRAM (controller NbarT).
- `rd_cycle` in 1: high on a BIST compare cycle; `expected` and `actual` are valid.
- `phase` in 3: pattern phase, the upper three BIST counter bits.
- `addr` in `size`: BIST address of the current cycle.
- `expected` in `length`: decoder test pattern.
- `actual` in `length`: SRAM read data.
- `pop_valid` out 1: the FIFO head entry is valid.
- `pop_ready` in 1: the reader accepts the head entry.
- `pop_addr` out `size`: head entry address.
- `pop_phase` out 3: head entry phase.
- `pop_syndrome` out `length`: head entry `expected ^ actual`.
- `fail_count` out 16: number of mismatches this session, saturating.
- `overflow` out 1: sticky; at least one mismatch was dropped because the FIFO was full.
- `done` out 1: the session has ended (state DONE).

## Operation
- States: IDLE, ARMED, LOGGING, DONE.
  - IDLE → ARMED on `arm`.
  - ARMED → LOGGING on the first cycle with `test_active`=1.
  - LOGGING → DONE on the first cycle with `test_active`=0.
  - DONE → ARMED on `arm`.
- `arm` in any state, including LOGGING, does all of the following on that edge:
  - flushes the FIFO;
  - clears `fail_count` and `overflow`;
  - moves the block to ARMED.
- `arm` has priority over a pop and over a capture in the same cycle.
- Capture condition: state is LOGGING, `test_active`=1, `rd_cycle`=1, and `expected`≠`actual`.
  - No capture occurs in ARMED, so the LOGGING entry cycle itself is never captured.
- On a capture:
  - `fail_count` increments and saturates at 16'hFFFF.
  - An entry {`addr`, `phase`, `expected^actual`} is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the entry is dropped and `overflow` is set to 1.
- FIFO behaviour:
  - First-word-fall-through; entries leave in capture order.
  - Read and write pointers wrap modulo `depth`.
  - An extra wrap bit distinguishes full from empty.
- Pop occurs when `pop_valid` && `pop_ready`. Pops are legal in every state, so the log can be drained live during LOGGING.
- `pop_ready` while empty has no effect.
- The FIFO contents persist in DONE and IDLE until popped or re-armed.

## Timing
- Reset values:
  - state IDLE;
  - `pop_valid`=0; `pop_addr`, `pop_phase`, `pop_syndrome` all 0;
  - `fail_count`=0, `overflow`=0, `done`=0.
- Capture latency: a mismatch sampled at edge N gives `pop_valid`=1 with its data after edge N, when the FIFO was empty.
- `fail_count` and `overflow` update on the capturing edge.
- `done` goes high after the edge that enters DONE and low after the edge that leaves it.
- While `pop_valid`=1 and `pop_ready`=0, all `pop_*` outputs are stable.
- Full throughput: one push and one pop per cycle, sustained.
- Asserting `rst` mid-session clears everything immediately; no partial entry survives.

## Configuration
- `BIST_LOG_FIRST_FAIL_EN` defined:
  - Adds outputs `first_fail_valid` (1 bit) and `first_fail_addr` (`size` bits).
  - These latch the address of the first mismatch of the session, even if that entry overflowed.
  - Both are cleared by `rst` and `arm`.
- `BIST_LOG_FIRST_FAIL_EN` undefined: those ports and registers do not exist, and all other behaviour is identical.

## Test plan
- Clean run: arm, then 64 compare cycles with `expected`=`actual`=8'h55, then drop `test_active` → `fail_count`=0, `pop_valid`=0, `overflow`=0, `done`=1.
- Single fail: mismatch at addr 6'h2A, phase 3, expected 8'hFF, actual 8'hF7 → the next cycle shows `pop_valid`=1, `pop_addr`=6'h2A, `pop_phase`=3, `pop_syndrome`=8'h08, `fail_count`=1.
- Overflow with `depth`=8: 10 mismatches at addrs 0..9 with `pop_ready`=0 → `fail_count`=10, `overflow`=1, and draining yields addrs 0..7 in order; with the macro, `first_fail_addr`=0.
- Full + simultaneous pop: FIFO full, mismatch at addr 6'h3F in the same cycle as a pop → no drop, `overflow` stays 0, and the ninth entry popped is 6'h3F.
- Re-arm mid-session: 3 entries queued during LOGGING, then `arm` together with `pop_ready`=1 → after that edge `pop_valid`=0, `fail_count`=0, state ARMED.
- Async reset: assert `rst` between clock edges while `pop_valid`=1 → all outputs go to 0 immediately, before the next edge.
